// File: rtl/fetch_unit.sv
// Sequential instruction prefetch into a small PC-tagged FIFO, handed to decode over valid/ready.
// Read issued in cycle N is visible at the FIFO head in cycle N+2; 1 instr/cycle sustained.
// Issue is credit-gated on registered occupancy + in-flight read; decode stalls via ir_ready.
module fetch_unit #(
    parameter int PC_W  = 7,
    parameter int DEPTH = 4,
    parameter int IW    = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    output logic [PC_W-1:0]              imem_addr,
    output logic                         imem_rd,
    input  logic [IW-1:0]                imem_rdata,
    output logic [IW-1:0]                ir_out,
    output logic [PC_W-1:0]              ir_pc,
    output logic                         ir_valid,
    input  logic                         ir_ready,
    input  logic                         redirect,
    input  logic [PC_W-1:0]              redirect_pc,
    input  logic                         halt,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [IW-1:0]   dat;
        logic [PC_W-1:0] pc;
    } ent_t;

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_STALL = 2'd1,
        S_FLUSH = 2'd2
    } fetch_state_t;

    fetch_state_t    state;
    logic [PC_W-1:0] fetch_pc;
    logic [PC_W-1:0] inflight_pc;
    logic            inflight;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    ent_t            mem [DEPTH];

    logic            credit_ok;
    logic            push;
    logic            pop;

    // Credit counts the in-flight read so its response always has a slot; pops earn no credit.
    assign credit_ok = ({1'b0, count} + {{CW{1'b0}}, inflight}) < (CW + 1)'(DEPTH);
    assign imem_rd   = !rst && !halt && !redirect && credit_ok;
    assign imem_addr = fetch_pc;

    // FLUSH already clears inflight; the state term keeps the discard explicit.
    assign push     = inflight && !redirect && (state != S_FLUSH);
    assign ir_valid = (count != '0);
    assign pop      = ir_valid && ir_ready;

    assign ir_out = mem[rd_ptr].dat;
    assign ir_pc  = mem[rd_ptr].pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_RUN;
            fetch_pc    <= '0;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (redirect) begin
                state <= S_FLUSH;
            end else if (imem_rd) begin
                state <= S_RUN;
            end else begin
                state <= S_STALL;
            end

            if (redirect) begin
                fetch_pc <= redirect_pc;
                inflight <= 1'b0;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                count    <= '0;
            end else begin
                inflight <= imem_rd;
                if (imem_rd) begin
                    fetch_pc    <= fetch_pc + PC_W'(1);
                    inflight_pc <= fetch_pc;
                end
                if (push) begin
                    mem[wr_ptr] <= '{dat: imem_rdata, pc: inflight_pc};
                    wr_ptr      <= wr_ptr + AW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                case ({push, pop})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: instruction memory returns 0xA000_0000 + address one cycle after a read.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [6:0]  imem_addr;
    logic        imem_rd;
    logic [31:0] imem_rdata;
    logic [31:0] ir_out;
    logic [6:0]  ir_pc;
    logic        ir_valid;
    logic        ir_ready = 1'b0;
    logic        redirect = 1'b0;
    logic [6:0]  redirect_pc = '0;
    logic        halt = 1'b0;
    logic [2:0]  count;

    int nvec = 0;
    int nerr = 0;

    logic [6:0]  last_addr = '0;
    logic [6:0]  got_pc[$];
    logic [31:0] got_dat[$];

    fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .imem_addr   (imem_addr),
        .imem_rd     (imem_rd),
        .imem_rdata  (imem_rdata),
        .ir_out      (ir_out),
        .ir_pc       (ir_pc),
        .ir_valid    (ir_valid),
        .ir_ready    (ir_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt        (halt),
        .count       (count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) last_addr <= imem_addr;
    assign imem_rdata = 32'hA000_0000 + {25'd0, last_addr};

    always @(negedge clk) begin
        if (!rst && ir_valid && ir_ready) begin
            got_pc.push_back(ir_pc);
            got_dat.push_back(ir_out);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, actual=running required=finished");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic apply_reset(input logic rdy);
        step();
        rst = 1'b1;
        halt = 1'b0;
        redirect = 1'b0;
        redirect_pc = '0;
        ir_ready = rdy;
        step();
        rst = 1'b0;
        got_pc.delete();
        got_dat.delete();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        nvec++; if (ir_valid !== 1'b0) begin nerr++; $display("FAIL reset_ir_valid actual=%b required=0", ir_valid); end
        nvec++; if (imem_rd !== 1'b0) begin nerr++; $display("FAIL reset_imem_rd actual=%b required=0", imem_rd); end
        nvec++; if (count !== 3'd0) begin nerr++; $display("FAIL reset_count actual=%0d required=0", count); end
        nvec++; if (ir_out !== 32'd0) begin nerr++; $display("FAIL reset_ir_out actual=%h required=0", ir_out); end
        nvec++; if (ir_pc !== 7'd0) begin nerr++; $display("FAIL reset_ir_pc actual=%h required=0", ir_pc); end
        nvec++; if (imem_addr !== 7'd0) begin nerr++; $display("FAIL reset_imem_addr actual=%h required=0", imem_addr); end
    endtask

    task automatic test_stream();
        apply_reset(1'b1);
        nvec++; if (imem_rd !== 1'b1) begin nerr++; $display("FAIL stream_c0_imem_rd actual=%b required=1", imem_rd); end
        nvec++; if (imem_addr !== 7'd0) begin nerr++; $display("FAIL stream_c0_addr actual=%0d required=0", imem_addr); end
        nvec++; if (ir_valid !== 1'b0) begin nerr++; $display("FAIL stream_c0_valid actual=%b required=0", ir_valid); end
        step();
        nvec++; if (ir_valid !== 1'b0) begin nerr++; $display("FAIL stream_c1_valid actual=%b required=0", ir_valid); end
        nvec++; if (imem_addr !== 7'd1) begin nerr++; $display("FAIL stream_c1_addr actual=%0d required=1", imem_addr); end
        step();
        nvec++; if (ir_valid !== 1'b1) begin nerr++; $display("FAIL stream_c2_valid actual=%b required=1", ir_valid); end
        nvec++; if (ir_pc !== 7'd0) begin nerr++; $display("FAIL stream_c2_pc actual=%0d required=0", ir_pc); end
        nvec++; if (ir_out !== 32'hA000_0000) begin nerr++; $display("FAIL stream_c2_data actual=%h required=a0000000", ir_out); end
        step();
        nvec++; if (ir_pc !== 7'd1) begin nerr++; $display("FAIL stream_c3_pc actual=%0d required=1", ir_pc); end
        nvec++; if (ir_out !== 32'hA000_0001) begin nerr++; $display("FAIL stream_c3_data actual=%h required=a0000001", ir_out); end
        nvec++; if (count !== 3'd1) begin nerr++; $display("FAIL stream_c3_count actual=%0d required=1", count); end
        step();
        nvec++; if (ir_pc !== 7'd2) begin nerr++; $display("FAIL stream_c4_pc actual=%0d required=2", ir_pc); end
        nvec++; if (imem_rd !== 1'b1) begin nerr++; $display("FAIL stream_c4_imem_rd actual=%b required=1", imem_rd); end
    endtask

    task automatic test_backpressure();
        apply_reset(1'b0);
        for (int i = 0; i < 4; i++) step();
        nvec++; if (imem_rd !== 1'b0) begin nerr++; $display("FAIL bp_c4_imem_rd actual=%b required=0", imem_rd); end
        nvec++; if (count !== 3'd3) begin nerr++; $display("FAIL bp_c4_count actual=%0d required=3", count); end
        step();
        nvec++; if (count !== 3'd4) begin nerr++; $display("FAIL bp_c5_count actual=%0d required=4", count); end
        nvec++; if (imem_rd !== 1'b0) begin nerr++; $display("FAIL bp_c5_imem_rd actual=%b required=0", imem_rd); end
        nvec++; if (imem_addr !== 7'd4) begin nerr++; $display("FAIL bp_c5_addr actual=%0d required=4", imem_addr); end
        step();
        nvec++; if (count !== 3'd4) begin nerr++; $display("FAIL bp_c6_count actual=%0d required=4", count); end
        step();
        ir_ready = 1'b1;
        for (int i = 0; i < 12; i++) step();
        nvec++;
        if (got_pc.size() < 8) begin
            nerr++; $display("FAIL bp_delivered_count actual=%0d required>=8", got_pc.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                nvec++;
                if (got_pc[i] !== 7'(i) || got_dat[i] !== 32'hA000_0000 + i) begin
                    nerr++; $display("FAIL bp_order[%0d] actual=pc%0d/%h required=pc%0d/%h", i, got_pc[i], got_dat[i], i, 32'hA000_0000 + i);
                end
            end
        end
    endtask

    task automatic test_redirect();
        logic [6:0] exp_pc [5];
        exp_pc = '{7'h00, 7'h01, 7'h40, 7'h41, 7'h42};
        apply_reset(1'b1);
        for (int i = 0; i < 4; i++) step();
        ir_ready = 1'b0;
        step();
        step();
        nvec++; if (count !== 3'd3) begin nerr++; $display("FAIL redir_pre_count actual=%0d required=3", count); end
        nvec++; if (imem_addr !== 7'd6) begin nerr++; $display("FAIL redir_pre_addr actual=%0d required=6", imem_addr); end
        redirect = 1'b1;
        redirect_pc = 7'h40;
        #1;
        nvec++; if (imem_rd !== 1'b0) begin nerr++; $display("FAIL redir_cycle_imem_rd actual=%b required=0", imem_rd); end
        step();
        redirect = 1'b0;
        #1;
        nvec++; if (count !== 3'd0) begin nerr++; $display("FAIL redir_count actual=%0d required=0", count); end
        nvec++; if (ir_valid !== 1'b0) begin nerr++; $display("FAIL redir_valid actual=%b required=0", ir_valid); end
        nvec++; if (imem_addr !== 7'h40) begin nerr++; $display("FAIL redir_addr actual=%h required=40", imem_addr); end
        nvec++; if (imem_rd !== 1'b1) begin nerr++; $display("FAIL redir_imem_rd actual=%b required=1", imem_rd); end
        ir_ready = 1'b1;
        for (int i = 0; i < 6; i++) step();
        nvec++;
        if (got_pc.size() < 5) begin
            nerr++; $display("FAIL redir_delivered_count actual=%0d required>=5", got_pc.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                nvec++;
                if (got_pc[i] !== exp_pc[i] || got_dat[i] !== 32'hA000_0000 + {25'd0, exp_pc[i]}) begin
                    nerr++; $display("FAIL redir_order[%0d] actual=pc%h/%h required=pc%h", i, got_pc[i], got_dat[i], exp_pc[i]);
                end
            end
        end
    endtask

    task automatic test_wrap();
        logic [6:0]  exp_pc [3];
        logic [31:0] exp_dat [3];
        exp_pc  = '{7'd127, 7'd0, 7'd1};
        exp_dat = '{32'hA000_007F, 32'hA000_0000, 32'hA000_0001};
        apply_reset(1'b1);
        redirect = 1'b1;
        redirect_pc = 7'd127;
        #1;
        nvec++; if (imem_rd !== 1'b0) begin nerr++; $display("FAIL wrap_redir_imem_rd actual=%b required=0", imem_rd); end
        step();
        redirect = 1'b0;
        #1;
        nvec++; if (imem_addr !== 7'd127) begin nerr++; $display("FAIL wrap_addr actual=%0d required=127", imem_addr); end
        for (int i = 0; i < 6; i++) step();
        nvec++;
        if (got_pc.size() < 3) begin
            nerr++; $display("FAIL wrap_delivered_count actual=%0d required>=3", got_pc.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                nvec++;
                if (got_pc[i] !== exp_pc[i] || got_dat[i] !== exp_dat[i]) begin
                    nerr++; $display("FAIL wrap_order[%0d] actual=pc%0d/%h required=pc%0d/%h", i, got_pc[i], got_dat[i], exp_pc[i], exp_dat[i]);
                end
            end
        end
    endtask

    task automatic test_halt();
        apply_reset(1'b1);
        for (int i = 0; i < 5; i++) step();
        halt = 1'b1;
        #1;
        nvec++; if (imem_rd !== 1'b0) begin nerr++; $display("FAIL halt_imem_rd actual=%b required=0", imem_rd); end
        nvec++; if (imem_addr !== 7'd5) begin nerr++; $display("FAIL halt_addr actual=%0d required=5", imem_addr); end
        step();
        step();
        nvec++; if (count !== 3'd0) begin nerr++; $display("FAIL halt_drain_count actual=%0d required=0", count); end
        nvec++; if (ir_valid !== 1'b0) begin nerr++; $display("FAIL halt_drain_valid actual=%b required=0", ir_valid); end
        step();
        nvec++; if (count !== 3'd0) begin nerr++; $display("FAIL halt_hold_count actual=%0d required=0", count); end
        halt = 1'b0;
        #1;
        nvec++; if (imem_rd !== 1'b1) begin nerr++; $display("FAIL halt_resume_imem_rd actual=%b required=1", imem_rd); end
        nvec++; if (imem_addr !== 7'd5) begin nerr++; $display("FAIL halt_resume_addr actual=%0d required=5", imem_addr); end
        for (int i = 0; i < 8; i++) step();
        nvec++;
        if (got_pc.size() < 10) begin
            nerr++; $display("FAIL halt_delivered_count actual=%0d required>=10", got_pc.size());
        end else begin
            for (int i = 0; i < 10; i++) begin
                nvec++;
                if (got_pc[i] !== 7'(i) || got_dat[i] !== 32'hA000_0000 + i) begin
                    nerr++; $display("FAIL halt_order[%0d] actual=pc%0d/%h required=pc%0d", i, got_pc[i], got_dat[i], i);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        apply_reset(1'b0);
        for (int i = 0; i < 4; i++) step();
        nvec++; if (count !== 3'd3) begin nerr++; $display("FAIL arst_pre_count actual=%0d required=3", count); end
        #1;
        rst = 1'b1;
        #1;
        nvec++; if (ir_valid !== 1'b0) begin nerr++; $display("FAIL arst_valid actual=%b required=0", ir_valid); end
        nvec++; if (imem_rd !== 1'b0) begin nerr++; $display("FAIL arst_imem_rd actual=%b required=0", imem_rd); end
        nvec++; if (count !== 3'd0) begin nerr++; $display("FAIL arst_count actual=%0d required=0", count); end
        step();
        rst = 1'b0;
        ir_ready = 1'b1;
        #1;
        nvec++; if (imem_addr !== 7'd0) begin nerr++; $display("FAIL arst_restart_addr actual=%0d required=0", imem_addr); end
        nvec++; if (imem_rd !== 1'b1) begin nerr++; $display("FAIL arst_restart_imem_rd actual=%b required=1", imem_rd); end
        step();
        step();
        nvec++; if (ir_valid !== 1'b1 || ir_pc !== 7'd0) begin nerr++; $display("FAIL arst_first_pc actual=v%b/pc%0d required=v1/pc0", ir_valid, ir_pc); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_wrap();
        test_halt();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
